serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b) with a start/done handshake.
// Two cascaded half-subtractors and a registered borrow process one bit per clock.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT            state;
   stateT            stateNext;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic [WIDTH-1:0] sdNext;
   logic             br;
   logic             brNext;
   logic [CntW-1:0]  cnt;
   logic             loadOps;
   logic             stepBit;
   logic             lastBit;
   logic             h;
   logic             p;
   logic             d;
   logic             q;

   // Returns {borrow, difference} of x - y for single bits.
   function automatic logic [1:0] halfSub(input logic x, input logic y);
      return {~x & y, x ^ y};
   endfunction

   assign {p, h} = halfSub(sa[0], sb[0]);
   assign {q, d} = halfSub(h, br);
   assign brNext = p | q;
   assign sdNext = {d, sd[WIDTH-1:1]};

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      loadOps   = 1'b0;
      stepBit   = 1'b0;
      lastBit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               loadOps   = 1'b1;
               stateNext = RUN;
            end
         end
         RUN: begin
            stepBit = 1'b1;
            if (cnt == LastCnt) begin
               lastBit   = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Operand shifters, borrow and counter; diff/borrow only move on the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         sd     <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         if (loadOps) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
         end else if (stepBit) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            sd  <= sdNext;
            br  <= brNext;
            cnt <= lastBit ? '0 : cnt + CntW'(1);
         end
         if (lastBit) begin
            diff   <= sdNext;
            borrow <= brNext;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, scoreboard on done,
// plus hand-written sequences for ignored starts, async reset and back-to-back.
module tb_serial_subtractor;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 40;

   typedef struct packed {
      logic [7:0] diff;
      logic       borrow;
   } resultT;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] expDiff;
      logic       expBorrow;
   } vectorT;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a     = 8'h00;
   logic [7:0] b     = 8'h00;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow;

   resultT sbQ[$];
   int     errors    = 0;
   int     checks    = 0;
   int     doneCount = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic resultT model(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] wide;
      resultT     r;
      wide     = {1'b0, x} - {1'b0, y};
      r.diff   = wide[7:0];
      r.borrow = wide[8];
      return r;
   endfunction

   // Scoreboard: every done pops the oldest expected result.
   always @(posedge clk) begin : monitor
      resultT expR;
      #1;
      checkOutput("busyDoneExclusive", 32'(busy & done), 32'd0);
      if (done) begin
         doneCount++;
         checkOutput("doneHasPendingResult", 32'(sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) begin
            expR = sbQ.pop_front();
            checkOutput("diff", 32'(diff), 32'(expR.diff));
            checkOutput("borrow", 32'(borrow), 32'(expR.borrow));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input resultT expR);
      int cycles;
      int busyCycles;
      int startDones;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      sbQ.push_back(expR);
      @(posedge clk);
      #1;
      start      = 1'b0;
      startDones = doneCount;
      checkOutput("busyAtAccept", 32'(busy), 32'd1);
      busyCycles = busy ? 1 : 0;
      cycles     = 0;
      while (!done && cycles < TIMEOUT) begin
         @(posedge clk);
         #1;
         cycles++;
         if (busy) busyCycles++;
      end
      checkOutput("doneLatency", 32'(cycles), 32'(WIDTH));
      checkOutput("busyCycles", 32'(busyCycles), 32'(WIDTH));
      @(posedge clk);
      #1;
      checkOutput("donePulseWidth", 32'(done), 32'd0);
      checkOutput("donePulseCount", 32'(doneCount - startDones), 32'd1);
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      vectorT vecs[8];
      int     startDones;
      int     accepts;
      int     firstAcc;
      int     secondAcc;
      logic   prevBusy;

      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
      vecs[5] = '{8'h01, 8'h02, 8'hFF, 1'b1};
      vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
      vecs[7] = '{8'hC8, 8'h37, 8'h91, 1'b0};

      // Asynchronous reset before any clock edge.
      #2;
      rst_n = 1'b0;
      #2;
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetDiff", 32'(diff), 32'd0);
      checkOutput("resetBorrow", 32'(borrow), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, {vecs[i].expDiff, vecs[i].expBorrow});
      end

      // Start pulsed again mid-run with changing operands must be ignored.
      startDones = doneCount;
      @(negedge clk);
      a     = 8'h10;
      b     = 8'h01;
      start = 1'b1;
      sbQ.push_back('{8'h0F, 1'b0});
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 8'hFF;
      b     = 8'h77;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 8'h00;
      b     = 8'h01;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 8'h33;
      b     = 8'hCC;
      checkOutput("busyAfterIgnoredStart", 32'(busy), 32'd1);
      repeat (17) @(posedge clk);
      #2;
      checkOutput("ignoredStartDones", 32'(doneCount - startDones), 32'd1);
      checkOutput("ignoredStartIdle", 32'(busy), 32'd0);
      checkOutput("ignoredStartHeldDiff", 32'(diff), 32'h0F);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      a     = 8'hAA;
      b     = 8'h55;
      start = 1'b1;
      sbQ.push_back(model(8'hAA, 8'h55));
      @(posedge clk);
      #1;
      start      = 1'b0;
      startDones = doneCount;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midResetBusy", 32'(busy), 32'd0);
      checkOutput("midResetDone", 32'(done), 32'd0);
      checkOutput("midResetDiff", 32'(diff), 32'd0);
      checkOutput("midResetBorrow", 32'(borrow), 32'd0);
      sbQ.delete();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("inResetBusy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      checkOutput("abortedNoDone", 32'(doneCount - startDones), 32'd0);
      applyStimulus(8'hAA, 8'h55, '{8'h55, 1'b0});

      // Start held high: accepts only every WIDTH+2 cycles.
      startDones = doneCount;
      @(negedge clk);
      a     = 8'h3C;
      b     = 8'hC3;
      start = 1'b1;
      sbQ.push_back(model(8'h3C, 8'hC3));
      prevBusy  = busy;
      accepts   = 0;
      firstAcc  = -1;
      secondAcc = -1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (busy && !prevBusy) begin
            if (accepts == 0) firstAcc = k;
            else if (accepts == 1) secondAcc = k;
            accepts++;
         end
         prevBusy = busy;
         if (k == 0) begin
            a = 8'h5A;
            b = 8'h0F;
            sbQ.push_back(model(8'h5A, 8'h0F));
         end
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("backToBackAccepts", 32'(accepts), 32'd2);
      checkOutput("backToBackFirst", 32'(firstAcc), 32'd0);
      checkOutput("backToBackSecond", 32'(secondAcc), 32'(WIDTH + 2));
      checkOutput("backToBackDones", 32'(doneCount - startDones), 32'd2);
      checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
